// File: rtl/writeback_regfile.sv
// MEM/WB pipeline register, writeback mux and RV64 integer register file.
// Two combinational read ports bypass the in-flight writeback so decode never sees stale data.
module writeback_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNTW  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_data,
  input  logic            stall,
  input  logic            flush,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] ValA,
  output logic [XLEN-1:0] ValB,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [AW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [CNTW-1:0] retired_count
);

  // Flow control: an instruction in WB (wb_valid) completes on the first edge
  // with stall=0; stall freezes it in place, flush replaces the incoming one with a bubble.
  logic            reg_write_q;
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      reg_write_q <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else if (!stall) begin
      if (flush) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid    <= in_valid;
        reg_write_q <= in_reg_write;
        wb_rd       <= in_rd;
        wb_data     <= in_mem_to_reg ? in_mem_data : in_alu_result;
      end
    end
  end

  assign wb_en = wb_valid & reg_write_q & (wb_rd != '0) & ~stall;

  // x0 is never written because wb_en excludes rd==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (wb_valid && !stall) begin
      retired_count <= retired_count + CNTW'(1);
    end
  end

  always_comb begin
    ValA = '0;
    if (rs1 != '0) ValA = (wb_en && rs1 == wb_rd) ? wb_data : regs[rs1];
  end

  always_comb begin
    ValB = '0;
    if (rs2 != '0) ValB = (wb_en && rs2 == wb_rd) ? wb_data : regs[rs2];
  end

endmodule
